// File: rtl/window_gen_pkg.sv
// Shared pixel and window types for the 3x3 neighbourhood pipeline
// (window generator and median filter).
package window_gen_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam int PIX_W = $bits(pixel_t);
  localparam int WIN   = 3;

  typedef pixel_t window_t [WIN][WIN];

endpackage

// File: rtl/window_gen_line_buffer.sv
// One line of pixel storage: combinational read, synchronous write, no reset.
module line_buffer
  import window_gen_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIX_W-1:0]         wdata,
  output logic [PIX_W-1:0]         rdata
);

  pixel_t mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_gen.sv
// Turns a raster pixel stream into 3x3 windows, one per interior pixel,
// using two line buffers and a shifting 3x3 register window.
module window_gen
  import window_gen_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     axis_i_vld,
  output logic                     axis_i_rdy,
  input  logic [PIX_W-1:0]         axis_i_data,
  output logic                     axis_o_vld,
  input  logic                     axis_o_rdy,
  output logic [WIN*WIN*PIX_W-1:0] axis_o_data
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  window_t       win;
  pixel_t        pix;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
  logic          accept;
  logic          emit;
  logic          last_col;
  logic          last_row;

  assign pix        = pixel_t'(axis_i_data);
  assign axis_i_rdy = axis_o_rdy | ~axis_o_vld;
  assign accept     = axis_i_vld & axis_i_rdy;
  assign last_col   = (col == CW'(WIDTH - 1));
  assign last_row   = (row == RW'(HEIGHT - 1));
  assign emit       = accept && (row >= RW'(2)) && (col >= CW'(2));

  // lb0 always holds the previous line; its old entry cascades into lb1
  line_buffer #(.DEPTH(WIDTH)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (pix),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(WIDTH)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      axis_o_vld <= 1'b0;
    end else begin
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (emit) begin
        axis_o_vld <= 1'b1;
      end else if (axis_o_rdy) begin
        axis_o_vld <= 1'b0;
      end
    end
  end

  // Window only moves on accept, so a stalled output keeps its data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN; j++) begin
          win[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < WIN; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= pixel_t'(lb1_rd);
      win[1][2] <= pixel_t'(lb0_rd);
      win[2][2] <= pix;
    end
  end

  always_comb begin
    axis_o_data = '0;
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN; j++) begin
        axis_o_data[(i*WIN+j)*PIX_W +: PIX_W] = win[i][j];
      end
    end
  end

endmodule
